instr_executor: RTL and testbench

- Downstream consumer of instr_register. On `start`, walks a run of register slots, driving `read_pointer` and capturing `instruction_word`.
- Decodes the opcode and computes a 64-bit signed result for each slot.
- Emits each result over a valid/ready handshake to the result checker/scoreboard stage.
- Gives the testbench a DUT-side golden executor and feeds later writeback logic.

---
 rtl/instr_exec_pkg.sv | 40 ++++
 rtl/instr_executor_alu.sv | 42 ++++
 rtl/instr_executor.sv | 105 ++++++++++
 tb/tb_instr_executor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_exec_pkg.sv
// Shared types for the instruction executor: opcodes, operand/result types,
// the 68-bit instruction word layout and the executor FSM states.
package instr_exec_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int CNT_WIDTH  = 6;
    localparam int INSTR_W    = 68;
    localparam int RESULT_W   = 64;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0]           operand_t;
    typedef logic signed [RESULT_W-1:0]   result_t;
    typedef logic [ADDR_WIDTH-1:0]        address_t;

    // Opcode occupies the top 4 bits of the 68-bit word.
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/instr_executor_alu.sv
// Purely combinational executor ALU: decodes one instruction word and produces
// a 64-bit signed result plus an error flag for div/mod by zero or bad opcodes.
module instr_alu
    import instr_exec_pkg::*;
(
    input  logic [INSTR_W-1:0]         instr,
    output logic signed [RESULT_W-1:0] result,
    output logic                       err
);

    instruction_t iw;
    result_t      a;
    result_t      b;

    assign iw = instruction_t'(instr);
    assign a  = {{32{iw.op_a[31]}}, iw.op_a};
    assign b  = {{32{iw.op_b[31]}}, iw.op_b};

    // Operands are widened to 64 bits first, so -2^31 / -1 yields +2^31 cleanly.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (iw.opc)
            ZERO:  result = '0;
            PASSA: result = a;
            PASSB: result = b;
            ADD:   result = a + b;
            SUB:   result = a - b;
            MULT:  result = a * b;
            DIV: begin
                if (b == '0) err = 1'b1;
                else         result = a / b;
            end
            MOD: begin
                if (b == '0) err = 1'b1;
                else         result = a % b;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_executor.sv
// Walks a run of instruction-register slots, executes each instruction and
// hands every result downstream over a valid/ready handshake.
module instr_executor
    import instr_exec_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int CNT_W  = CNT_WIDTH
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          first_ptr,
    input  logic [CNT_W-1:0]           count,
    output logic [ADDR_W-1:0]          read_pointer,
    input  logic [INSTR_W-1:0]         instruction_word,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [RESULT_W-1:0] res_data,
    output logic [ADDR_W-1:0]          res_ptr,
    output logic                       res_err,
    output logic                       busy,
    output logic                       done
);

    state_t                      state;
    state_t                      next_state;
    logic [ADDR_W-1:0]           ptr;
    logic [CNT_W-1:0]            rem;
    logic [INSTR_W-1:0]          iw_q;
    logic signed [RESULT_W-1:0]  alu_result;
    logic                        alu_err;

    instr_alu u_alu (
        .instr  (iw_q),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = (count == '0) ? DONE : FETCH;
            end
            FETCH: next_state = EXEC;
            EXEC:  next_state = OUT;
            OUT: begin
                if (res_ready) next_state = (rem == CNT_W'(1)) ? DONE : FETCH;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        res_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    assign read_pointer = ptr;

    // The done pulse is registered so it lands the cycle after DONE, with busy already low.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            rem      <= '0;
            iw_q     <= '0;
            res_data <= '0;
            res_ptr  <= '0;
            res_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr <= first_ptr;
                        rem <= count;
                    end
                end
                FETCH: begin
                    iw_q    <= instruction_word;
                    res_ptr <= ptr;
                end
                EXEC: begin
                    res_data <= alu_result;
                    res_err  <= alu_err;
                end
                OUT: begin
                    if (res_ready) begin
                        ptr <= ptr + ADDR_W'(1);
                        rem <= rem - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_executor.sv
// Scoreboard bench for instr_executor: directed runs push expected results into
// a queue, and a negedge monitor pops and compares on every accepted result.
module tb_instr_executor;
    import instr_exec_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [4:0]                 first_ptr;
    logic [5:0]                 count;
    logic [4:0]                 read_pointer;
    logic [67:0]                instruction_word;
    logic                       res_valid;
    logic                       res_ready;
    logic signed [63:0]         res_data;
    logic [4:0]                 res_ptr;
    logic                       res_err;
    logic                       busy;
    logic                       done;

    logic [67:0] mem [32];

    typedef struct {
        logic [63:0] data;
        logic [4:0]  ptr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   done_seen  = 0;
    int   accepted   = 0;

    instr_executor dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_ptr        (first_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_ptr          (res_ptr),
        .res_err          (res_err),
        .busy             (busy),
        .done             (done)
    );

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    function automatic logic [67:0] mk(input logic [3:0] opc, input int a, input int b);
        return {opc, a[31:0], b[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input longint data, input int ptr, input bit err);
        exp_t e;
        e.data = data;
        e.ptr  = ptr[4:0];
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int fp, input int cnt);
        start     = 1'b1;
        first_ptr = fp[4:0];
        count     = cnt[5:0];
        tick();
        start     = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        for (int i = 0; i < budget && !res_valid; i++) tick();
        checkOutput("res_valid_wait", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic waitDone(input int d0, input int budget);
        for (int i = 0; i < budget && done_seen == d0; i++) tick();
        repeat (3) tick();
        checkOutput("done_pulses", 64'(done_seen - d0), 64'd1);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a result is accepted at the coming edge when valid and ready are both high.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (!reset && res_valid && res_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got ptr %0d data 0x%0h, expected none", res_ptr, res_data);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("res_data", res_data, mon_e.data);
                checkOutput("res_ptr", 64'(res_ptr), 64'(mon_e.ptr));
                checkOutput("res_err", 64'(res_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int a0;
        int lat;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset     = 1'b1;
        start     = 1'b0;
        res_ready = 1'b1;
        first_ptr = '0;
        count     = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_read_pointer", 64'(read_pointer), 64'd0);
        checkOutput("rst_res_data", res_data, 64'd0);
        checkOutput("rst_res_ptr", 64'(res_ptr), 64'd0);
        checkOutput("rst_res_err", 64'(res_err), 64'd0);

        $display("[TB] basic run");
        mem[0] = mk(4'd3, 5, 7);
        mem[1] = mk(4'd4, 3, 10);
        mem[2] = mk(4'd5, -4, 6);
        pushExp(12, 0, 0);
        pushExp(-7, 1, 0);
        pushExp(-24, 2, 0);
        d0 = done_seen;
        applyStimulus(0, 3);
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("first_latency", 64'(lat), 64'd3);
        waitDone(d0, 40);

        $display("[TB] backpressure");
        mem[4] = mk(4'd3, 100, -1);
        res_ready = 1'b0;
        pushExp(99, 4, 0);
        d0 = done_seen;
        applyStimulus(4, 1);
        waitValid(10);
        a0 = accepted;
        repeat (5) begin
            tick();
            checkOutput("bp_valid", 64'(res_valid), 64'd1);
            checkOutput("bp_data", res_data, 64'd99);
            checkOutput("bp_ptr", 64'(res_ptr), 64'd4);
        end
        res_ready = 1'b1;
        waitDone(d0, 20);
        checkOutput("bp_accepted", 64'(accepted - a0), 64'd1);

        $display("[TB] pointer wrap");
        mem[30] = mk(4'd1, 11, 22);
        mem[31] = mk(4'd2, 11, 22);
        mem[0]  = mk(4'd4, 0, 5);
        mem[1]  = mk(4'd5, -70000, 70000);
        pushExp(11, 30, 0);
        pushExp(22, 31, 0);
        pushExp(-5, 0, 0);
        pushExp(-64'sd4900000000, 1, 0);
        d0 = done_seen;
        applyStimulus(30, 4);
        waitDone(d0, 60);

        $display("[TB] divide and modulo edges");
        mem[8]  = mk(4'd6, 7, -2);
        mem[9]  = mk(4'd7, -7, 2);
        mem[10] = mk(4'd6, 9, 0);
        mem[11] = mk(4'd6, 32'h8000_0000, -1);
        mem[12] = mk(4'd12, 5, 3);
        mem[13] = mk(4'd7, 5, 0);
        pushExp(-3, 8, 0);
        pushExp(-1, 9, 0);
        pushExp(0, 10, 1);
        pushExp(64'sd2147483648, 11, 0);
        pushExp(0, 12, 1);
        pushExp(0, 13, 1);
        d0 = done_seen;
        applyStimulus(8, 6);
        waitDone(d0, 80);

        $display("[TB] zero count");
        d0 = done_seen;
        a0 = accepted;
        applyStimulus(0, 0);
        checkOutput("zc_done_early", 64'(done), 64'd0);
        tick();
        checkOutput("zc_done_pulse", 64'(done), 64'd1);
        checkOutput("zc_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        checkOutput("zc_no_results", 64'(accepted - a0), 64'd0);

        $display("[TB] start while busy");
        pushExp(-5, 0, 0);
        pushExp(-64'sd4900000000, 1, 0);
        d0 = done_seen;
        a0 = accepted;
        applyStimulus(0, 2);
        tick();
        applyStimulus(20, 5);
        waitDone(d0, 40);
        checkOutput("busy_start_count", 64'(accepted - a0), 64'd2);

        $display("[TB] reset mid-run");
        res_ready = 1'b0;
        d0 = done_seen;
        applyStimulus(8, 3);
        waitValid(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mr_res_valid", 64'(res_valid), 64'd0);
        checkOutput("mr_busy", 64'(busy), 64'd0);
        repeat (4) tick();
        checkOutput("mr_no_done", 64'(done_seen - d0), 64'd0);
        res_ready = 1'b1;
        mem[20] = mk(4'd3, 1, 1);
        pushExp(2, 20, 0);
        d0 = done_seen;
        applyStimulus(20, 1);
        waitDone(d0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
